// File: rtl/cpu_pkg.sv
// Shared types and constants for the cache line-fill path.
package cpu_pkg;

  localparam int unsigned LINE_OFF_BITS = 5;
  localparam int unsigned BEATS         = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBeat,
    StAck
  } state_e;

  typedef enum logic {
    OwnIc,
    OwnDc
  } owner_e;

endpackage

// File: rtl/fill_line_buf.sv
// Beat buffer for one cache line: BEATS slots of BEAT_W bits, exposed as a flat line.
module fill_line_buf
  import cpu_pkg::*;
#(
  parameter int unsigned BEAT_W = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [1:0]              idx_i,
  input  logic [BEAT_W-1:0]       wdata_i,
  output logic [BEATS*BEAT_W-1:0] line_o
);

  logic [BEAT_W-1:0] slot_q [BEATS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (we_i) begin
      slot_q[idx_i] <= wdata_i;
    end
  end

  // Beat k lands at bits [k*BEAT_W +: BEAT_W].
  always_comb begin
    line_o = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      line_o[i*BEAT_W +: BEAT_W] = slot_q[i];
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Round-robin line-fill sequencer for i-cache and d-cache misses over one memory read port.
module mem_fill_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_miss,
  input  logic [ADDR_W-1:0] ic_miss_addr,
  input  logic              dc_miss,
  input  logic [ADDR_W-1:0] dc_miss_addr,
  output logic              ic_miss_ack,
  output logic              dc_miss_ack,
  output logic [LINE_W-1:0] fill_data,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0] fill_hold_q;
  logic [ADDR_W-1:0] fill_addr_hold_q;
  logic [LINE_W-1:0] buf_line;
  logic              buf_we;
  logic [ADDR_W-1:0] ic_line_addr, dc_line_addr;

  assign ic_line_addr = {ic_miss_addr[ADDR_W-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
  assign dc_line_addr = {dc_miss_addr[ADDR_W-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt_q;
    buf_we       = 1'b0;

    case (state_q)
      StIdle: begin
        if (ic_miss || dc_miss) begin
          // On a tie the requester not served last wins.
          if (ic_miss && (!dc_miss || (last_grant_q == OwnDc))) begin
            owner_d = OwnIc;
            addr_d  = ic_line_addr;
          end else begin
            owner_d = OwnDc;
            addr_d  = dc_line_addr;
          end
          last_grant_d = owner_d;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          beat_cnt_d = '0;
          state_d    = StBeat;
        end
      end
      StBeat: begin
        if (mem_rvalid) begin
          buf_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      owner_q          <= OwnDc;
      last_grant_q     <= OwnDc;
      addr_q           <= '0;
      beat_cnt_q       <= '0;
      fill_hold_q      <= '0;
      fill_addr_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      // Keep the delivered line visible after ACK while the buffer refills.
      if (state_q == StAck) begin
        fill_hold_q      <= buf_line;
        fill_addr_hold_q <= addr_q;
      end
    end
  end

  fill_line_buf #(
    .BEAT_W (BEAT_W)
  ) u_line_buf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (buf_we),
    .idx_i   (beat_cnt_q),
    .wdata_i (mem_rdata),
    .line_o  (buf_line)
  );

  assign mem_req     = (state_q == StReq);
  assign mem_addr    = addr_q;
  assign busy        = (state_q != StIdle);
  assign ic_miss_ack = (state_q == StAck) && (owner_q == OwnIc);
  assign dc_miss_ack = (state_q == StAck) && (owner_q == OwnDc);
  assign fill_data   = (state_q == StAck) ? buf_line : fill_hold_q;
  assign fill_addr   = (state_q == StAck) ? addr_q : fill_addr_hold_q;

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Sequences line fills for the i-cache and d-cache over one shared 64-bit main-memory read port.
- Arbitrates round-robin between the two miss requesters.
- Issues a line-aligned read, assembles four 64-bit beats into a 256-bit line, and returns it with a one-cycle ack to the winner.
- Sits between i_cache/d_cache miss interfaces and the memory model, at cpu top level.

Parameters:
- ADDR_W, 32, address width.
- BEAT_W, 64, memory read data width.
- LINE_W, 256, cache line width; BEATS = LINE_W/BEAT_W = 4; line offset bits = 5.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- ic_miss  in  1  i-cache miss request, held high until ic_miss_ack
- ic_miss_addr  in  ADDR_W  i-cache miss address
- dc_miss  in  1  d-cache miss request, held high until dc_miss_ack
- dc_miss_addr  in  ADDR_W  d-cache miss address
- ic_miss_ack  out  1  one-cycle pulse: fill_data/fill_addr valid for i-cache
- dc_miss_ack  out  1  one-cycle pulse: fill_data/fill_addr valid for d-cache
- fill_data  out  LINE_W  assembled line, beat k at bits [64k+63:64k]
- fill_addr  out  ADDR_W  line address of the returned fill, bits [4:0]=0
- mem_req  out  1  read request to memory
- mem_addr  out  ADDR_W  line-aligned read address
- mem_gnt  in  1  memory accepts request when mem_req & mem_gnt
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  BEAT_W  read beat data, ascending beat order
- busy  out  1  high in any state other than IDLE

Behaviour:
- States:
  - IDLE: if no miss is pending, stay.
    - One miss pending: grant it.
    - Both pending: grant the requester not granted last. last_grant resets to DC, so IC wins the first tie.
    - On grant: latch owner, latch {miss_addr[31:5], 5'b0} into addr_q, update last_grant, go to REQ.
  - REQ: mem_req=1, mem_addr=addr_q. On mem_req & mem_gnt go to BEAT with beat_cnt=0. Otherwise hold with the request stable.
  - BEAT: on each mem_rvalid, write mem_rdata into slot beat_cnt and increment beat_cnt (2-bit). Idle cycles without rvalid are allowed. The rvalid with beat_cnt==3 goes to ACK.
  - ACK: exactly one cycle.
    - Assert ic_miss_ack or dc_miss_ack per owner.
    - fill_data = assembled buffer; fill_addr = addr_q.
    - Next state IDLE.
- Requester contract:
  - Miss is deasserted in the cycle after its ack.
  - The next IDLE cycle samples the new miss values, so back-to-back service of the other requester starts at IDLE+1.
  - Address changes while a miss is held after grant are ignored; addr_q is used.
- Latency with zero-wait memory (gnt and 4 consecutive rvalids): miss rises in cycle 0 (IDLE), REQ cycle 1, beats cycles 2–5, ack cycle 6.
- mem_rvalid outside BEAT is ignored and does not touch the buffer or counter.
- fill_data and fill_addr hold their last values outside ACK. Consumers qualify them with ack only.
- Reset values, asserted on the cycle rst_n=0 is sampled:
  - state=IDLE, beat_cnt=0, last_grant=DC, addr_q=0, buffer=0.
  - All outputs 0: ic_miss_ack, dc_miss_ack, mem_req, busy, mem_addr=0, fill_data=0, fill_addr=0.
- Reset mid-fill: the transaction is abandoned with no ack. Beats arriving after reset are ignored because the state is IDLE.
- Only one transaction is outstanding at a time. No write path.

Decomposition:
- Shared package (cpu_pkg) holds:
  - state enum {IDLE, REQ, BEAT, ACK}
  - owner enum {OWN_IC, OWN_DC}
  - LINE_OFF_BITS=5, BEATS=4
- Sub-module fill_line_buf holds the 4×64 beat buffer with write enable and index. It exposes the concatenated 256-bit line.
- The FSM, arbiter and address latch stay in mem_fill_arbiter.

Test Plan:
- Single IC miss at 0x0000_1013, mem_gnt=1, beats 0x11..,0x22..,0x33..,0x44.. on 4 consecutive cycles -> mem_addr=0x0000_1000 in REQ; ic_miss_ack at cycle 6; fill_data[63:0]=beat0, [255:192]=beat3; fill_addr=0x1000; dc_miss_ack never asserted.
- IC and DC miss rise in the same cycle (0x2000, 0x3040) -> IC served first (mem_addr 0x2000, ic ack). DC is then granted the cycle after IC drops its miss, with mem_addr=0x3040 and dc_miss_ack.
- Next tie after a DC win -> IC granted; after an IC win -> DC granted (round-robin verified over 4 ties).
- mem_gnt low for 3 cycles, then rvalid gaps between beats -> mem_req and mem_addr stable until gnt; beat_cnt advances only on rvalid; single ack after the 4th beat.
- rst_n=0 for one cycle after beat 2 of a DC fill -> all outputs 0 next cycle, no dc_miss_ack. A stray rvalid afterwards is ignored. The held dc_miss is re-granted and re-fetched from REQ.
- mem_rvalid pulses while IDLE or REQ -> buffer unchanged, no state change.
